// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive (and transmit) paths.
//   - uart_rx_state_t : receiver FSM state encoding
//   - DATA_BITS       : payload bits per frame
//   - tick_div()      : clocks per oversample tick, CLK_FREQ/(BAUD*OVS),
//                       integer division
//   BUS_WIDTH normally comes from the shared bus header. If that header has
//   not been read before this file, it defaults to 32 here.
// -----------------------------------------------------------------------------
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4,
        PARITY = 3'd5
    } uart_rx_state_t;

    function automatic int unsigned tick_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        return clk_freq / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Oversample tick generator shared by the UART receive and transmit sides.
//   A counter runs 0..DIV-1 while en_i is high and emits a one-cycle tick_o
//   at terminal count. With en_i low or clr_i high the counter is held at 0,
//   so the first tick after enabling arrives DIV cycles later.
//
//   Ports:
//     clk     in  1  system clock
//     rst_n   in  1  asynchronous active-low reset
//     en_i    in  1  count enable
//     clr_i   in  1  synchronous clear (dominates en_i)
//     tick_o  out 1  one-cycle pulse every DIV enabled cycles
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = en_i && !clr_i && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART receiver, 8N1 with 16x (OVS) oversampling. The received byte sits in
//   a one-entry holding register, read by the CPU as {zeros, byte}.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     Defined   : 8E1 frames, PARITY state between DATA and STOP, extra
//                 sticky output parity_err_o.
//     Undefined : 8N1 frames, no parity_err_o port.
//
//   Ports:
//     clk          in  1          system clock
//     rst_n        in  1          asynchronous active-low reset
//     rx_i         in  1          serial line, idles high, asynchronous
//     rd_en_i      in  1          one-cycle pop of the holding register
//     rdata_o      out BUS_WIDTH  {zeros, received byte}
//     rx_valid_o   out 1          holding register has an unread byte
//     frame_err_o  out 1          sticky: last stop bit sampled as 0
//     overrun_o    out 1          sticky: an unread byte was overwritten
//     busy_o       out 1          FSM not in IDLE
//     parity_err_o out 1          (UART_RX_PARITY_EN only) sticky parity error
//
//   OVS must be a power of two and at least 8.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned OVS      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_i,
    input  logic                  rd_en_i,
    output logic [`BUS_WIDTH-1:0] rdata_o,
    output logic                  rx_valid_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  busy_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_err_o
`endif
);

    localparam int unsigned TICK_DIV = tick_div(CLK_FREQ, BAUD, OVS);
    localparam int TPW = $clog2(OVS);
    localparam int BIW = $clog2(DATA_BITS);
    localparam logic [TPW-1:0] MID_POS  = TPW'(OVS / 2 - 1);
    localparam logic [TPW-1:0] LAST_POS = TPW'(OVS - 1);
    localparam logic [BIW-1:0] LAST_BIT = BIW'(DATA_BITS - 1);

    // ---------------------------------------------------------------
    // Input synchronizer; resets to the idle-line level so a reset
    // never looks like a start bit by itself.
    // ---------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    uart_rx_state_t         state_q,    state_d;
    logic [TPW-1:0]         tick_pos_q, tick_pos_d;
    logic [BIW-1:0]         bit_idx_q,  bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic [DATA_BITS-1:0]   rdata_q,    rdata_d;
    logic                   valid_q,    valid_d;
    logic                   ferr_q,     ferr_d;
    logic                   ovr_q,      ovr_d;
    logic                   busy_q,     busy_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit_q,  par_bit_d;
    logic                   perr_q,     perr_d;
`endif

    logic tick;
    logic load;
    logic pop;

    // The tick counter only runs during a frame; holding it clear in IDLE
    // restarts its phase at every start-bit edge.
    uart_baud_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q != IDLE),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tick_pos_d = tick_pos_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
`endif
        load       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    tick_pos_d = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (tick_pos_q == MID_POS) begin
                        // Re-check the line at the centre of the start bit;
                        // a high level means the falling edge was noise.
                        if (!rx_s) begin
                            state_d    = DATA;
                            bit_idx_d  = '0;
                            tick_pos_d = '0;
                        end else begin
                            state_d    = IDLE;
                        end
                    end else begin
                        tick_pos_d = tick_pos_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (tick_pos_q == LAST_POS) begin
                        tick_pos_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        tick_pos_d = tick_pos_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tick_pos_q == LAST_POS) begin
                        tick_pos_d = '0;
                        par_bit_d  = rx_s;
                        state_d    = STOP;
                    end else begin
                        tick_pos_d = tick_pos_q + 1'b1;
                    end
                end
            end
`endif

            STOP: begin
                if (tick) begin
                    if (tick_pos_q == LAST_POS) begin
                        tick_pos_d = '0;
                        load       = 1'b1;
                        // A low stop bit usually means a held-low line;
                        // park in BREAK so it cannot produce more bytes.
                        state_d    = rx_s ? IDLE : BREAK;
                    end else begin
                        tick_pos_d = tick_pos_q + 1'b1;
                    end
                end
            end

            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Holding register and sticky flags. A pop clears the old flags
    // first, then a simultaneous load applies the new byte's status.
    // ---------------------------------------------------------------
    assign pop = rd_en_i && valid_q;

    always_comb begin
        rdata_d = rdata_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif

        if (pop) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
        end

        if (load) begin
            rdata_d = shift_q;
            valid_d = 1'b1;
            if (!rx_s) begin
                ferr_d = 1'b1;
            end
            if (valid_q && !rd_en_i) begin
                ovr_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to 0.
            if (^{shift_q, par_bit_q}) begin
                perr_d = 1'b1;
            end
`endif
        end

        busy_d = (state_d != IDLE);
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_pos_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rdata_q    <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_pos_q <= tick_pos_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign rdata_o     = {{(`BUS_WIDTH - DATA_BITS){1'b0}}, rdata_q};
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx. Runs the receiver at a reduced line rate
//   (TICK_DIV = 5, 80 clocks per bit). A table of frame/pop records drives the
//   main path; hand-written sequences cover the start glitch, the pop on the
//   load cycle, the held-low line, parity (UART_RX_PARITY_EN) and a reset
//   mid-frame.
// -----------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CLK_FREQ = 8_000_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned OVS      = 16;
    localparam int TICK_DIV = 5;
    localparam int BIT_CLKS = TICK_DIV * OVS;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Edges from the start-bit drive edge to the stop-bit sample edge:
    // 3 edges through the synchronizer into START, then half a bit to the
    // start centre plus one full bit per data/parity/stop bit.
    localparam int STOP_EDGE = 3 + TICK_DIV * (OVS / 2 + OVS * (8 + PAR_BITS + 1));

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  rx_i = 1'b0;
    logic                  rd_en_i = 1'b0;
    logic [`BUS_WIDTH-1:0] rdata_o;
    logic                  rx_valid_o;
    logic                  frame_err_o;
    logic                  overrun_o;
    logic                  busy_o;
`ifdef UART_RX_PARITY_EN
    logic                  parity_err_o;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .OVS      (OVS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .rd_en_i     (rd_en_i),
        .rdata_o     (rdata_o),
        .rx_valid_o  (rx_valid_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err_o(parity_err_o)
`endif
    );

    typedef struct {
        logic       pop_first;
        logic       send;
        logic [7:0] data;
        logic [7:0] exp_rdata;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(data[i]);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit((^data) ^ par_flip);
`else
        if (par_flip) begin
            $display("note: parity flip ignored in 8N1 build");
        end
`endif
        drive_bit(stop_bit);
    endtask

    task automatic pop();
        rd_en_i = 1'b1;
        @(posedge clk);
        #1;
        rd_en_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                pop  send data   rdata  v     ferr  ovr
        vecs[0] = '{1'b0, 1'b1, 8'h55, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'h81, 8'h81, 1'b1, 1'b0, 1'b0};

        // ---- reset with the line low ----
        rst_n = 1'b0;
        rx_i  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_valid", {31'b0, rx_valid_o}, 32'h0);
        check("rst_ferr", {31'b0, frame_err_o}, 32'h0);
        check("rst_ovr", {31'b0, overrun_o}, 32'h0);
        check("rst_busy", {31'b0, busy_o}, 32'h0);
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // ---- table-driven frames ----
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].pop_first) pop();
            if (vecs[v].send) send_frame(vecs[v].data, 1'b1, 1'b0);
            $display("vec %0d pop=%0b send=%0b data=0x%02h", v, vecs[v].pop_first,
                     vecs[v].send, vecs[v].data);
            check($sformatf("v%0d_rdata", v), rdata_o, {24'h0, vecs[v].exp_rdata});
            check($sformatf("v%0d_valid", v), {31'b0, rx_valid_o}, {31'b0, vecs[v].exp_valid});
            check($sformatf("v%0d_ferr", v), {31'b0, frame_err_o}, {31'b0, vecs[v].exp_ferr});
            check($sformatf("v%0d_ovr", v), {31'b0, overrun_o}, {31'b0, vecs[v].exp_ovr});
        end

        // ---- start-bit glitch ----
        pop();
        rx_i = 1'b0;
        repeat (2 * TICK_DIV) @(posedge clk);
        #1;
        check("glitch_busy_during", {31'b0, busy_o}, 32'h1);
        repeat (2 * TICK_DIV) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (20 * TICK_DIV) @(posedge clk);
        #1;
        check("glitch_busy_after", {31'b0, busy_o}, 32'h0);
        check("glitch_valid", {31'b0, rx_valid_o}, 32'h0);

        // ---- pop on the exact load cycle of a second byte ----
        send_frame(8'h34, 1'b1, 1'b0);
        check("first_unread_valid", {31'b0, rx_valid_o}, 32'h1);
        fork
            send_frame(8'h12, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1;
                rd_en_i = 1'b1;
                @(posedge clk);
                #1;
                rd_en_i = 1'b0;
            end
        join
        check("same_valid", {31'b0, rx_valid_o}, 32'h1);
        check("same_rdata", rdata_o, 32'h12);
        check("same_ovr", {31'b0, overrun_o}, 32'h0);
        check("same_ferr", {31'b0, frame_err_o}, 32'h0);

        // ---- stop bit low, line held low ----
        pop();
        send_frame(8'hFF, 1'b0, 1'b0);
        check("brk_valid", {31'b0, rx_valid_o}, 32'h1);
        check("brk_ferr", {31'b0, frame_err_o}, 32'h1);
        check("brk_rdata", rdata_o, 32'hFF);
        check("brk_busy", {31'b0, busy_o}, 32'h1);
        repeat (3 * 10 * BIT_CLKS) @(posedge clk);
        #1;
        check("brk_busy_held", {31'b0, busy_o}, 32'h1);
        check("brk_no_new_byte", {31'b0, overrun_o}, 32'h0);
        check("brk_rdata_held", rdata_o, 32'hFF);
        rx_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("brk_exit_busy", {31'b0, busy_o}, 32'h0);
        pop();
        check("brk_pop_ferr", {31'b0, frame_err_o}, 32'h0);
        check("brk_pop_valid", {31'b0, rx_valid_o}, 32'h0);

`ifdef UART_RX_PARITY_EN
        // ---- parity: 0x07 has odd weight, so even parity bit is 1 ----
        send_frame(8'h07, 1'b1, 1'b1);
        check("par0_perr", {31'b0, parity_err_o}, 32'h1);
        check("par0_rdata", rdata_o, 32'h07);
        pop();
        check("par_pop_perr", {31'b0, parity_err_o}, 32'h0);
        send_frame(8'h07, 1'b1, 1'b0);
        check("par1_perr", {31'b0, parity_err_o}, 32'h0);
        check("par1_valid", {31'b0, rx_valid_o}, 32'h1);
        pop();
`endif

        // ---- reset asserted mid-frame ----
        rx_i = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("midrst_busy_before", {31'b0, busy_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy_o}, 32'h0);
        check("midrst_rdata", rdata_o, 32'h0);
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("postrst_busy", {31'b0, busy_o}, 32'h0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("postrst_rdata", rdata_o, 32'h5A);
        check("postrst_valid", {31'b0, rx_valid_o}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
